// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared helpers for the registered stream demultiplexer.
//   sel_onehot : one-hot decode of a channel index, zero when the index is
//                not below the channel count.
//   sat_inc    : increment that saturates at the all-ones value of a given width.
package stream_demux_pkg;

    localparam int unsigned MAX_CH = 16;

    function automatic logic [MAX_CH-1:0] sel_onehot(input int unsigned idx,
                                                     input int unsigned num_ch);
        logic [MAX_CH-1:0] oh;
        oh = '0;
        if (idx < num_ch && idx < MAX_CH) begin
            oh[idx[3:0]] = 1'b1;
        end
        return oh;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input int unsigned w);
        logic [31:0] lim;
        lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// demux_slot: one-entry output register with a valid flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture din and mark the slot valid
//   din        : payload to capture
//   ready      : consumer ready; drains the slot when valid
//   valid      : slot holds a beat
//   dout       : held payload (kept after draining)
//   free       : slot can accept a beat this cycle (empty or draining)
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] dout,
    output logic              free
);

    assign free = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-NUM_CH stream demultiplexer.
//   in_valid/in_ready/in_data : input stream
//   in_sel    : unicast destination index
//   in_bcast  : send to every enabled channel, in_sel ignored
//   ch_en     : per-channel enable mask (gates new loads only)
//   out_valid/out_ready/out_data : per-channel streams, channel k at
//               out_data[k*DATA_W +: DATA_W]
//   drop_cnt  : saturating count of beats with no enabled destination
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    input  logic [NUM_CH-1:0]        ch_en,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]         drop_cnt
);

    logic [MAX_CH-1:0] sel_oh;
    logic [NUM_CH-1:0] tgt;
    logic [NUM_CH-1:0] free;
    logic [NUM_CH-1:0] load;
    logic              acc;
    logic              unused_sel_oh;

    always_comb begin
        sel_oh = sel_onehot(32'(in_sel), NUM_CH);
        tgt    = in_bcast ? ch_en : (sel_oh[NUM_CH-1:0] & ch_en);
    end

    // Upper decode bits are always zero for NUM_CH < MAX_CH.
    assign unused_sel_oh = ^sel_oh;

    // All-or-nothing: every targeted slot must be free, so a broadcast
    // never partially delivers. An empty target mask is always ready.
    assign in_ready = &(free | ~tgt);
    assign acc      = in_valid && in_ready;
    assign load     = {NUM_CH{acc}} & tgt;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(.DATA_W(DATA_W)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .din   (in_data),
            .ready (out_ready[k]),
            .valid (out_valid[k]),
            .dout  (out_data[k*DATA_W +: DATA_W]),
            .free  (free[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (acc && tgt == '0) begin
            drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), CNT_W));
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic [1:0]  in_sel = '0;
    logic        in_bcast = 1'b0;
    logic [3:0]  ch_en = 4'b1111;
    logic [3:0]  out_ready = 4'b1111;

    logic        in_ready_a, in_ready_b;
    logic [3:0]  out_valid_a;
    logic [2:0]  out_valid_b;
    logic [31:0] out_data_a;
    logic [23:0] out_data_b;
    logic [15:0] drop_cnt_a;
    logic [1:0]  drop_cnt_b;

    int nchk = 0;
    int nerr = 0;

    // Reference configuration: 4 channels, 16-bit counter.
    stream_demux #(.DATA_W(8), .NUM_CH(4), .SEL_W(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast), .ch_en(ch_en),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .drop_cnt(drop_cnt_a)
    );

    // 3 channels (in_sel=3 out of range) with a 2-bit saturating counter.
    stream_demux #(.DATA_W(8), .NUM_CH(3), .SEL_W(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast), .ch_en(ch_en[2:0]),
        .out_valid(out_valid_b), .out_ready(out_ready[2:0]), .out_data(out_data_b),
        .drop_cnt(drop_cnt_b)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per configuration c (0 = 4ch/16b, 1 = 3ch/2b): held beat per channel
    // and the number of beats discarded so far.
    logic [3:0]  m_valid [2];
    logic [7:0]  m_data  [2][4];
    int unsigned m_drop  [2];

    function automatic int unsigned nch(input int c);
        return (c == 0) ? 4 : 3;
    endfunction

    function automatic int unsigned cmax(input int c);
        return (c == 0) ? 65535 : 3;
    endfunction

    function automatic logic [3:0] m_tgt(input int c);
        logic [3:0] dest;
        dest = '0;
        if (in_bcast) begin
            dest = ch_en;
        end else if (int'(in_sel) < int'(nch(c))) begin
            dest[in_sel] = ch_en[in_sel];
        end
        if (nch(c) == 3) dest[3] = 1'b0;
        return dest;
    endfunction

    function automatic logic m_ready(input int c);
        logic [3:0] dest;
        dest = m_tgt(c);
        for (int k = 0; k < 4; k++)
            if (dest[k] && m_valid[c][k] && !out_ready[k]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                m_valid[c] <= '0;
                m_drop[c]  <= 0;
                for (int k = 0; k < 4; k++) m_data[c][k] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                logic [3:0] dest;
                logic       take;
                dest = m_tgt(c);
                take = in_valid && m_ready(c);
                for (int k = 0; k < int'(nch(c)); k++) begin
                    if (take && dest[k]) begin
                        m_valid[c][k] <= 1'b1;
                        m_data[c][k]  <= in_data;
                    end else if (m_valid[c][k] && out_ready[k]) begin
                        m_valid[c][k] <= 1'b0;
                    end
                end
                if (take && dest == 4'b0 && m_drop[c] < cmax(c))
                    m_drop[c] <= m_drop[c] + 1;
            end
        end
    end

    // Compare every cycle, half a period after the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("a_in_ready",  32'(in_ready_a),  32'(m_ready(0)));
            chk("a_out_valid", 32'(out_valid_a), 32'(m_valid[0]));
            chk("a_out_data",  out_data_a, {m_data[0][3], m_data[0][2], m_data[0][1], m_data[0][0]});
            chk("a_drop_cnt",  32'(drop_cnt_a),  32'(m_drop[0][15:0]));
            chk("b_in_ready",  32'(in_ready_b),  32'(m_ready(1)));
            chk("b_out_valid", 32'(out_valid_b), 32'(m_valid[1][2:0]));
            chk("b_out_data",  32'(out_data_b), 32'({m_data[1][2], m_data[1][1], m_data[1][0]}));
            chk("b_drop_cnt",  32'(drop_cnt_b),  32'(m_drop[1][1:0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        // 1. Reset without a running clock.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_a_valid", 32'(out_valid_a), 32'h0);
        chk("rst_a_data",  out_data_a, 32'h0);
        chk("rst_a_drop",  32'(drop_cnt_a), 32'h0);
        chk("rst_b_valid", 32'(out_valid_b), 32'h0);
        chk("rst_b_drop",  32'(drop_cnt_b), 32'h0);
        clk_run = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready_a), 32'h1);
        step();

        // 2. Unicast sweep.
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] d;
            in_sel  = 2'(k);
            d       = 8'hA0 + 8'(k);
            in_data = d;
            step();
            chk("sweep_valid", 32'(out_valid_a), 32'(4'b0001 << k));
            chk("sweep_data",  32'(out_data_a[k*8 +: 8]), 32'(d));
        end
        in_valid = 1'b0;
        step();

        // 3. Backpressure on ch2.
        out_ready = 4'b1011;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h11;
        step();
        in_data = 8'h22;
        #1 chk("bp_not_ready", 32'(in_ready_a), 32'h0);
        step();
        chk("bp_held", 32'(out_data_a[23:16]), 32'h11);
        chk("bp_held_v", 32'(out_valid_a[2]), 32'h1);
        out_ready = 4'b1111;
        #1 chk("bp_ready", 32'(in_ready_a), 32'h1);
        step();
        chk("bp_loaded", 32'(out_data_a[23:16]), 32'h22);
        in_valid = 1'b0;
        step();
        chk("bp_drained", 32'(out_valid_a), 32'h0);

        // 4. Broadcast blocked by one full enabled slot.
        ch_en = 4'b1011;
        out_ready = 4'b1101;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h77;
        step();
        in_bcast = 1'b1; in_data = 8'h5A;
        #1 chk("bc_blocked", 32'(in_ready_a), 32'h0);
        step();
        chk("bc_no_load", 32'(out_valid_a), 32'b0010);
        out_ready = 4'b1111;
        step();
        chk("bc_valid", 32'(out_valid_a), 32'b1011);
        chk("bc_data",  {out_data_a[31:24], out_data_a[15:8], out_data_a[7:0]}, 32'h5A5A5A);
        in_valid = 1'b0; in_bcast = 1'b0;
        step();

        // 5. Drops: disabled channel, then broadcast with nothing enabled.
        ch_en = 4'b0111;
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'hD0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("drop_ready", 32'(in_ready_a), 32'h1);
            step();
            chk("drop_no_v3", 32'(out_valid_a[3]), 32'h0);
        end
        chk("drop_cnt3", 32'(drop_cnt_a), 32'd3);
        ch_en = 4'b0000; in_bcast = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("drop_cnt8", 32'(drop_cnt_a), 32'd8);
        chk("drop_sat",  32'(drop_cnt_b), 32'd3);
        in_valid = 1'b0; in_bcast = 1'b0; ch_en = 4'b1111;
        step();

        // 6. Mid-operation reset with every slot full.
        out_ready = 4'b0000;
        in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'h3C;
        step();
        in_valid = 1'b0; in_bcast = 1'b0;
        chk("full_valid", 32'(out_valid_a), 32'b1111);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid_a), 32'h0);
        chk("midrst_drop",  32'(drop_cnt_a), 32'h0);
        #1 rst_n = 1'b1;
        out_ready = 4'b1111;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h99;
        step();
        chk("post_valid", 32'(out_valid_a), 32'b0010);
        chk("post_data",  32'(out_data_a[15:8]), 32'h99);
        in_valid = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
Parametrised, registered 1-to-NUM_CH stream demultiplexer. It is the clocked successor to the combinational 1-to-4 demux gate. Each input beat is routed by in_sel to one output channel, or broadcast to all enabled channels. Every output channel has a valid/ready handshake with a one-entry output register. Beats whose destination is invalid or disabled are discarded and counted. The block sits between a single producer and NUM_CH independent consumers.

Parameters:
DATA_W, 8, payload width in bits
NUM_CH, 4, number of output channels (2..16)
SEL_W, 2, width of in_sel; must satisfy 2**SEL_W >= NUM_CH
CNT_W, 16, width of the drop counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  DATA_W  input payload
in_sel  in  SEL_W  destination channel index (unicast)
in_bcast  in  1  1 = send the beat to every enabled channel; in_sel is ignored
ch_en  in  NUM_CH  per-channel enable mask
out_valid  out  NUM_CH  per-channel output valid
out_ready  in  NUM_CH  per-channel consumer ready
out_data  out  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
drop_cnt  out  CNT_W  number of discarded beats, saturating

Behaviour:
- Reset, asynchronous, takes effect with no clock edge: out_valid=0, out_data=0, drop_cnt=0. Any buffered beats are lost.
- Per-channel slot k:
  - free_k = !out_valid[k] || out_ready[k]. A slot that is draining this cycle counts as free, so full throughput is kept.
  - Slot drains when out_valid[k] && out_ready[k].
  - Slot loads when load_k is set: out_valid[k] <= 1 and out_data[k] <= in_data.
  - Slot drains without a load: out_valid[k] <= 0 and out_data[k] holds its value.
- Target mask:
  - tgt = in_bcast ? ch_en : (onehot(in_sel) & ch_en).
  - in_sel >= NUM_CH gives onehot = 0.
- Ready rule: in_ready = &(free | ~tgt). This is all-or-nothing; a broadcast never partially delivers.
  - in_ready is combinational from out_ready, ch_en, in_sel and in_bcast.
  - Producer rule: in_valid must not depend on in_ready.
- Accept: acc = in_valid && in_ready. Then load_k = acc && tgt[k].
- Latency: a beat accepted on edge n is visible on out_valid/out_data immediately after edge n. That is one register stage; a beat is never combinational through.
- Drop:
  - If acc && tgt==0, in_ready is necessarily 1 and the beat is consumed.
  - drop_cnt increments by 1 and saturates at 2**CNT_W-1 (no wrap).
  - Drop cases: disabled channel, out-of-range in_sel, broadcast with ch_en==0.
- Channel disabled while its slot is full: the held beat still drains normally. ch_en only gates new loads.
- Simultaneous drain and load on the same slot in one cycle: the new beat replaces the old. This is legal because the old beat is consumed on that edge.
- in_data, in_sel and in_bcast are sampled only on acc and are don't-care otherwise.
- No internal state machine beyond the per-slot valid flags and the drop counter. There are no X outputs after reset.

Decomposition:
- Package stream_demux_pkg holds:
  - a function returning the onehot of an index, masked to NUM_CH and returning 0 when out of range;
  - a saturating-increment function for CNT_W.
- Sub-module demux_slot is one output register with a valid flag. It has ports clk, rst_n, load, din, ready, valid, dout and a free output. Instantiate it NUM_CH times with a generate loop.
- The top level holds the target-mask logic, in_ready, and the drop counter.

Test Plan:
All scenarios use DATA_W=8 and NUM_CH=4.
1. Reset: rst_n=0 with no clock running -> out_valid=4'b0000, drop_cnt=0. After release, with all ch_en=1 and all out_ready=1 -> in_ready=1.
2. Unicast sweep, matching the old gate's sel sequence:
   - Stimulus: in_sel=0,1,2,3 on consecutive cycles with in_data=0xA0..0xA3, out_ready=4'b1111.
   - Response: after each edge exactly one out_valid bit (bit k) is high, with out_data chunk k = 0xA0+k.
3. Backpressure:
   - Stimulus: out_ready[2]=0; send 0x11 then 0x22 to ch2.
   - Response: 0x11 is held and in_ready=0 while 0x22 is pending. Raise out_ready[2] -> 0x22 is loaded on that same edge. Nothing is lost or duplicated.
4. Broadcast:
   - Stimulus: ch_en=4'b1011, slot1 full, out_ready[1]=0, in_bcast=1, in_data=0x5A.
   - Response: in_ready=0 and no slot loads. Set out_ready[1]=1 -> channels 0, 1 and 3 each hold 0x5A after the edge; out_valid[2] stays 0.
5. Drop:
   - Stimulus: ch_en[3]=0; three beats to in_sel=3.
   - Response: in_ready=1 on every beat, drop_cnt=3, out_valid[3] never rises.
   - Then, with CNT_W=2, send 5 drops -> drop_cnt=3 (saturated).
6. Mid-operation reset: with all four slots full, pulse rst_n low between clock edges -> out_valid=0 immediately. After release, the next beat routes correctly.
